pupil_detect_stream: RTL and testbench
======================================

// Module: pupil_detect_stream
// PURPOSE
//  Streaming, parametrised successor pupil detector for the inward-facing camera path.
//  Consumes one frame pixel-by-pixel over a valid/ready handshake and finds, on each line,
//  the first dark run: a falling edge followed later by a rising edge.
//  Reports the centre and line of the widest run in the frame.
//  Sits between the camera line capture and the MSS-readable pupil registers.
// PARAMETERS
//  IMG_W      112  pixels per line (>=2)
//  IMG_H      112  lines per frame (>=1)
//  PIX_W      8    grayscale bits per pixel (0=black)
//  COORD_W    8    width of x/y/width outputs; must satisfy 2^COORD_W > max(IMG_W,IMG_H)
//  EARLY_STOP 0    1 = stop the frame at the first line narrower than the current max
// PORTS
//  clock        in   1        system clock, all logic on rising edge
//  reset        in   1        synchronous, active-high
//  thresh       in   PIX_W    edge threshold, sampled at every comparison
//  sof          in   1        qualifies a pixel beat as pixel (0,0) of a new frame
//  pix_valid    in   1        pixel beat valid
//  pix_data     in   PIX_W    pixel value, raster order
//  pix_ready    out  1        block accepts a beat when pix_valid & pix_ready
//  pupil_valid  out  1        one-cycle pulse, result fields updated this cycle
//  pupil_found  out  1        1 = at least one complete run was found in the last frame
//  pupil_x      out  COORD_W  (begin+end)>>1 of the widest run
//  pupil_y      out  COORD_W  line index of the widest run
//  pupil_width  out  COORD_W  end-begin of the widest run
// BEHAVIOUR
//  Reset: state=IDLE, pix_ready=0 for the reset cycle, pupil_valid=0, pupil_found=0.
//  Reset values: pupil_x and pupil_y all ones; pupil_width=0; all counters and flags cleared.
//  Reset mid-frame discards everything; the result outputs return to their reset values.
//  States:
//   IDLE: pix_ready=1. Beats without sof are dropped. A beat with sof -> SCAN, counted as x=0, y=0.
//   SCAN: pix_ready=1. Each accepted beat at x>0 compares prev vs cur (prev = beat at x-1).
//    - No run begun: if prev>cur and prev-cur>thresh, begin=x-1.
//    - Run begun, not ended: if cur>prev and cur-prev>thresh, end=x-1.
//    - Differences are unsigned and use no wrap: the opposite sign never triggers an edge.
//    - After end is set, the rest of the line is ignored (first run only).
//    - Beat at x=IMG_W-1 -> LINE_END.
//    - A beat with sof while in SCAN aborts the frame with no report and restarts at x=0, y=0.
//   LINE_END: 1 cycle, pix_ready=0.
//    - A line without both begin and end is ignored.
//    - Otherwise, if w=end-begin > max, update max, begin/end and best_y. Ties keep the earlier line.
//    - EARLY_STOP=1: if found_any and a complete w < max, go to REPORT, then DRAIN.
//    - y==IMG_H-1 -> REPORT. Otherwise increment y, clear x and the line flags, return to SCAN.
//   REPORT: 1 cycle, pix_ready=0.
//    - pupil_valid=1; pupil_found=found_any.
//    - If found_any: load pupil_x, pupil_y and pupil_width from the best run.
//    - If not found_any: pupil_x and pupil_y go all ones, pupil_width=0.
//    - Frame state is cleared. Next state: DRAIN if early-stopped, else IDLE.
//   DRAIN: pix_ready=1, beats are dropped until a beat with sof, which is handled as in IDLE.
//  Latency: pupil_valid asserts exactly 2 cycles after the handshake of the last pixel of the frame.
//  Outputs hold between reports. pupil_x is computed at COORD_W+1 bits before the shift.
// TESTING
//  T1 Uniform frame, all pixels 200, thresh=64 -> one pupil_valid, found=0, x=y=0xFF, width=0.
//  T2 Line 5 px[10]=200, px[11..29]=20, px[30]=200, other lines flat, thresh=64:
//     -> found=1, x=19, y=5, width=19, pupil_valid 2 cycles after the last beat.
//  T3 Widths 4/8/8/6 on lines 2/3/4/5, EARLY_STOP=0 -> y=3, width=8 (tie keeps earlier).
//     Same frame with EARLY_STOP=1 -> report after line 5 LINE_END, then trailing beats dropped.
//  T4 Drops of exactly 64 with thresh=64 -> no edge. Drops of 65 -> edge.
//     Rising edge before any falling edge in a line is ignored.
//  T5 sof reasserted at line 40 mid-frame -> no pupil_valid for the aborted frame.
//     The new frame reports normally. Random pix_valid gaps give identical results.
//  T6 reset pulsed mid-SCAN -> outputs return to reset values, next sof frame reports correctly.

Source files
------------

// File: rtl/pupil_detect_stream.sv
// Streaming pupil detector: finds the first dark run (falling then rising edge) on each
// line of a raster frame and reports the centre, line and width of the widest run.
module pupil_detect_stream #(
    parameter int IMG_W      = 112,
    parameter int IMG_H      = 112,
    parameter int PIX_W      = 8,
    parameter int COORD_W    = 8,
    parameter int EARLY_STOP = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PIX_W-1:0]   thresh,
    input  logic               sof,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
    output logic               pupil_valid,
    output logic               pupil_found,
    output logic [COORD_W-1:0] pupil_x,
    output logic [COORD_W-1:0] pupil_y,
    output logic [COORD_W-1:0] pupil_width
);

    // Handshake: a pixel beat transfers on a rising edge where pix_valid && pix_ready.
    typedef enum logic [2:0] {IDLE, SCAN, LINE_END, REPORT, DRAIN} state_t;

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    state_t             state, next_state;
    logic [COORD_W-1:0] x, y, run_beg, run_end, max_w, best_beg, best_end, best_y;
    logic [PIX_W-1:0]   prev;
    logic               begun, ended, found_any, early;
    logic               accept, start, fall, rise;
    logic               line_ok, line_better, stop_now, fin_found;
    logic [COORD_W-1:0] line_w, fin_beg, fin_end, fin_y, fin_w;
    logic [COORD_W:0]   x_sum;

    assign accept = pix_valid && pix_ready;
    assign start  = accept && sof;

    // Edges only count in the direction being tested; the opposite sign never wraps into one.
    assign fall = (prev > pix_data) && ((prev - pix_data) > thresh);
    assign rise = (pix_data > prev) && ((pix_data - prev) > thresh);

    assign line_ok     = begun && ended;
    assign line_w      = run_end - run_beg;
    assign line_better = line_ok && (!found_any || (line_w > max_w));
    assign stop_now    = (EARLY_STOP != 0) && found_any && line_ok && (line_w < max_w);

    // Best run including the line being closed this cycle, so REPORT can follow LINE_END directly.
    assign fin_found = found_any || line_ok;
    assign fin_beg   = line_better ? run_beg : best_beg;
    assign fin_end   = line_better ? run_end : best_end;
    assign fin_y     = line_better ? y       : best_y;
    assign fin_w     = line_better ? line_w  : max_w;
    assign x_sum     = {1'b0, fin_beg} + {1'b0, fin_end};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pix_ready  = 1'b0;
        case (state)
            IDLE, DRAIN: begin
                pix_ready = 1'b1;
                if (pix_valid && sof) next_state = SCAN;
            end
            SCAN: begin
                pix_ready = 1'b1;
                if (pix_valid && !sof && (x == LAST_X)) next_state = LINE_END;
            end
            LINE_END: next_state = (stop_now || (y == LAST_Y)) ? REPORT : SCAN;
            REPORT:   next_state = early ? DRAIN : IDLE;
            default:  next_state = IDLE;
        endcase
        if (reset) pix_ready = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x <= '0; y <= '0; prev <= '0; begun <= 1'b0; ended <= 1'b0;
            run_beg <= '0; run_end <= '0; max_w <= '0;
            best_beg <= '0; best_end <= '0; best_y <= '0;
            found_any <= 1'b0; early <= 1'b0;
            pupil_valid <= 1'b0; pupil_found <= 1'b0;
            pupil_x <= '1; pupil_y <= '1; pupil_width <= '0;
        end else begin
            pupil_valid <= 1'b0;
            if (start) begin
                // sof beat is pixel (0,0); any frame in progress is abandoned silently.
                x <= ONE; y <= '0; prev <= pix_data; begun <= 1'b0; ended <= 1'b0;
                max_w <= '0; found_any <= 1'b0; early <= 1'b0;
            end else begin
                case (state)
                    SCAN: if (accept) begin
                        prev <= pix_data;
                        x    <= x + ONE;
                        if (x != '0) begin
                            if (!begun) begin
                                if (fall) begin
                                    begun   <= 1'b1;
                                    run_beg <= x - ONE;
                                end
                            end else if (!ended && rise) begin
                                ended   <= 1'b1;
                                run_end <= x - ONE;
                            end
                        end
                    end
                    LINE_END: begin
                        if (line_better) begin
                            max_w <= line_w; best_beg <= run_beg;
                            best_end <= run_end; best_y <= y;
                        end
                        if (line_ok) found_any <= 1'b1;
                        x <= '0; y <= y + ONE; begun <= 1'b0; ended <= 1'b0;
                        if (next_state == REPORT) begin
                            pupil_valid <= 1'b1;
                            pupil_found <= fin_found;
                            early       <= stop_now;
                            if (fin_found) begin
                                pupil_x     <= x_sum[COORD_W:1];
                                pupil_y     <= fin_y;
                                pupil_width <= fin_w;
                            end else begin
                                pupil_x     <= '1;
                                pupil_y     <= '1;
                                pupil_width <= '0;
                            end
                        end
                    end
                    REPORT: begin
                        x <= '0; y <= '0; begun <= 1'b0; ended <= 1'b0;
                        max_w <= '0; best_beg <= '0; best_end <= '0; best_y <= '0;
                        found_any <= 1'b0; early <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pupil_detect_stream.sv
// Bench for pupil_detect_stream: two instances (EARLY_STOP 0 and 1) share one pixel stream;
// a frame-level model fills expected queues and per-instance monitors check every report.
module tb_pupil_detect_stream;
    localparam int W  = 40;
    localparam int H  = 48;
    localparam int CW = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] thresh = '0, pix_data = '0;
    logic       sof = 1'b0, pix_valid0 = 1'b0, pix_valid1 = 1'b0;
    logic       pix_ready0, pupil_valid0, pupil_found0;
    logic       pix_ready1, pupil_valid1, pupil_found1;
    logic [CW-1:0] pupil_x0, pupil_y0, pupil_width0, pupil_x1, pupil_y1, pupil_width1;

    pupil_detect_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .COORD_W(CW), .EARLY_STOP(0)) u_dut0 (
        .clock(clock), .reset(reset), .thresh(thresh), .sof(sof), .pix_valid(pix_valid0),
        .pix_data(pix_data), .pix_ready(pix_ready0), .pupil_valid(pupil_valid0),
        .pupil_found(pupil_found0), .pupil_x(pupil_x0), .pupil_y(pupil_y0),
        .pupil_width(pupil_width0));

    pupil_detect_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .COORD_W(CW), .EARLY_STOP(1)) u_dut1 (
        .clock(clock), .reset(reset), .thresh(thresh), .sof(sof), .pix_valid(pix_valid1),
        .pix_data(pix_data), .pix_ready(pix_ready1), .pupil_valid(pupil_valid1),
        .pupil_found(pupil_found1), .pupil_x(pupil_x1), .pupil_y(pupil_y1),
        .pupil_width(pupil_width1));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit found;
        int x;
        int y;
        int w;
        int trig;
    } exp_t;

    exp_t       exp_q0[$], exp_q1[$];
    int         hs0[int], hs1[int];
    int         n_checks = 0, n_fail = 0, beat_id = 0;
    logic [7:0] frame[H][W];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: whole-frame arithmetic ----------------
    task automatic push_exp(input bit es, input bit f, input int bb, input int be, input int by,
                            input int trig);
        exp_t e;
        e.found = f;
        e.x     = f ? (bb + be) / 2 : 255;
        e.y     = f ? by : 255;
        e.w     = f ? be - bb : 0;
        e.trig  = trig;
        if (es) exp_q1.push_back(e);
        else    exp_q0.push_back(e);
    endtask

    task automatic model_frame(input int nlines, input int th, input int base, input bit es);
        int best_w = -1, bb = 0, be = 0, by = 0;
        bit found = 0;
        for (int y = 0; y < nlines; y++) begin
            int b = -1, e = -1;
            for (int x = 1; x < W; x++) begin
                int p = frame[y][x-1];
                int c = frame[y][x];
                if (b < 0) begin
                    if (p - c > th) b = x - 1;
                end else if (e < 0 && x - 1 > b) begin
                    if (c - p > th) e = x - 1;
                end
            end
            if (b >= 0 && e >= 0) begin
                if (es && found && (e - b) < best_w) begin
                    push_exp(es, 1, bb, be, by, base + (y + 1) * W - 1);
                    return;
                end
                if ((e - b) > best_w) begin
                    best_w = e - b; bb = b; be = e; by = y;
                end
                found = 1;
            end
            if (y == H - 1) push_exp(es, found, bb, be, by, base + H * W - 1);
        end
    endtask

    // ---------------- monitors ----------------
    task automatic check_report(input bit es, input logic f, input logic [CW-1:0] px,
                                input logic [CW-1:0] py, input logic [CW-1:0] pw);
        exp_t e;
        int   hs;
        string tag = es ? "es1" : "es0";
        if ((es ? exp_q1.size() : exp_q0.size()) == 0) begin
            chk({tag, "_unexpected_report"}, 1, 0);
            return;
        end
        e  = es ? exp_q1.pop_front() : exp_q0.pop_front();
        if (es) hs = hs1.exists(e.trig) ? hs1[e.trig] : -1000;
        else    hs = hs0.exists(e.trig) ? hs0[e.trig] : -1000;
        chk({tag, "_found"},   int'(f),  int'(e.found));
        chk({tag, "_x"},       int'(px), e.x);
        chk({tag, "_y"},       int'(py), e.y);
        chk({tag, "_width"},   int'(pw), e.w);
        chk({tag, "_latency"}, (cyc + 1) - hs, 2);
    endtask

    always @(negedge clock)
        if (!reset && pupil_valid0) check_report(0, pupil_found0, pupil_x0, pupil_y0, pupil_width0);

    always @(negedge clock)
        if (!reset && pupil_valid1) check_report(1, pupil_found1, pupil_x1, pupil_y1, pupil_width1);

    // ---------------- driver ----------------
    task automatic send_beat(input logic [7:0] d, input bit s, input bit gaps);
        bit a0 = 0, a1 = 0, t0, t1;
        int tries = 0, hc;
        if (gaps && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) @(negedge clock);
        pix_data = d;
        sof      = s;
        while (!(a0 && a1)) begin
            pix_valid0 = !a0;
            pix_valid1 = !a1;
            #1;
            t0 = pix_valid0 && pix_ready0;
            t1 = pix_valid1 && pix_ready1;
            hc = cyc + 1;
            @(posedge clock);
            if (t0) begin a0 = 1; hs0[beat_id] = hc; end
            if (t1) begin a1 = 1; hs1[beat_id] = hc; end
            @(negedge clock);
            tries++;
            if (tries > 50) begin
                chk("handshake_timeout", tries, 0);
                break;
            end
        end
        pix_valid0 = 1'b0;
        pix_valid1 = 1'b0;
        sof        = 1'b0;
        beat_id++;
    endtask

    task automatic run_frame(input int th, input int nlines, input int extra, input bit gaps);
        int base = beat_id;
        thresh = 8'(th);
        model_frame(nlines, th, base, 0);
        model_frame(nlines, th, base, 1);
        for (int i = 0; i < nlines * W + extra; i++)
            send_beat(frame[i / W][i % W], i == 0, gaps);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        pix_valid0 = 1'b0;
        pix_valid1 = 1'b0;
        #1;
        chk("reset_ready0", int'(pix_ready0), 0);
        chk("reset_ready1", int'(pix_ready1), 0);
        @(negedge clock);
        chk("reset_valid0", int'(pupil_valid0), 0);
        chk("reset_found0", int'(pupil_found0), 0);
        chk("reset_x0",     int'(pupil_x0), 255);
        chk("reset_y0",     int'(pupil_y0), 255);
        chk("reset_w0",     int'(pupil_width0), 0);
        chk("reset_found1", int'(pupil_found1), 0);
        chk("reset_x1",     int'(pupil_x1), 255);
        chk("reset_w1",     int'(pupil_width1), 0);
        reset = 1'b0;
        #1;
        chk("post_reset_ready0", int'(pix_ready0), 1);
    endtask

    // ---------------- frame builders ----------------
    task automatic fill(input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) frame[y][x] = 8'(v);
    endtask

    task automatic set_run(input int y, input int b, input int w, input int lo);
        for (int x = b + 1; x <= b + w; x++) frame[y][x] = 8'(lo);
    endtask

    task automatic random_frame();
        for (int y = 0; y < H; y++) begin
            int base = $urandom_range(120, 255);
            for (int x = 0; x < W; x++) frame[y][x] = 8'(base - $urandom_range(0, 8));
            if ($urandom_range(0, 9) < 8) begin
                int w  = $urandom_range(1, 30);
                int b  = $urandom_range(0, W - 2 - w);
                int lo = $urandom_range(0, 60);
                for (int x = b + 1; x <= b + w; x++) frame[y][x] = 8'(lo + $urandom_range(0, 5));
                if ($urandom_range(0, 9) == 0)
                    for (int x = b + w + 1; x < W; x++) frame[y][x] = 8'(lo);
            end
        end
    endtask

    task automatic noise_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) frame[y][x] = 8'($urandom_range(0, 255));
    endtask

    task automatic t2_frame();
        fill(200);
        set_run(5, 10, 19, 20);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #900000;
        chk("watchdog_expired", 1, 0);
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // T1 uniform frame
        fill(200);
        run_frame(64, H, 0, 0);

        // T2 single run on line 5
        t2_frame();
        run_frame(64, H, 0, 0);

        // T3 widths 4/8/8/6, tie keeps earlier; EARLY_STOP instance stops after line 5
        fill(200);
        set_run(2, 5, 4, 20);
        set_run(3, 5, 8, 20);
        set_run(4, 5, 8, 20);
        set_run(5, 5, 6, 20);
        run_frame(64, H, 0, 0);

        // T4 threshold boundary and rising-before-falling
        fill(200);
        set_run(1, 9, 11, 136);
        set_run(2, 9, 11, 135);
        for (int x = 0; x < W; x++) frame[3][x] = 8'd100;
        for (int x = 5; x <= 9; x++) frame[3][x] = 8'd200;
        run_frame(64, H, 0, 0);

        // T5 aborted frame, then the T2 frame again with random valid gaps
        random_frame();
        run_frame($urandom_range(20, 60), 40, 0, 1);
        t2_frame();
        run_frame(64, H, 0, 1);

        // T6 reset mid-scan, then a clean frame
        t2_frame();
        run_frame(64, 20, 7, 0);
        do_reset();
        fill(200);
        set_run(2, 5, 4, 20);
        set_run(3, 5, 8, 20);
        set_run(4, 5, 8, 20);
        set_run(5, 5, 6, 20);
        run_frame(64, H, 0, 1);

        // randomized frames
        for (int k = 0; k < 3; k++) begin
            random_frame();
            run_frame($urandom_range(20, 60), H, 0, k[0]);
        end
        noise_frame();
        run_frame($urandom_range(40, 200), H, 0, 1);

        repeat (10) @(negedge clock);
        chk("pending_es0", exp_q0.size(), 0);
        chk("pending_es1", exp_q1.size(), 0);
        summary();
        $finish;
    end

endmodule
